// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider for DIV/DIVU/REM/REMU with start/done handshake
module seq_divider #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            div_zero
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PREP = 3'd1;
  localparam logic [2:0] ITER = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  logic [2:0]      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, rem_q, rem_d, quo_q, quo_d, bmag_q, bmag_d, result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            negq_q, negq_d, negr_q, negr_d, spec_q, spec_d, zero_q, zero_d, div_zero_q, div_zero_d;
  logic            sgn, ovf, ge;
  logic [XLEN-1:0] amag, bm, qfin, rfin;
  logic [XLEN:0]   rem_w, diff;
  assign sgn   = ~op_q[0];
  assign amag  = (sgn & a_q[XLEN-1]) ? -a_q : a_q;
  assign bm    = (sgn & b_q[XLEN-1]) ? -b_q : b_q;
  assign ovf   = sgn & (a_q == MIN_INT) & (&b_q);
  // rem < |b| holds, so a set borrow bit in the XLEN+1-bit difference means shifted rem < |b|
  assign rem_w = {rem_q, quo_q[XLEN-1]};
  assign diff  = rem_w - {1'b0, bmag_q};
  assign ge    = ~diff[XLEN];
  assign qfin  = negq_q ? -quo_q : quo_q;
  assign rfin  = negr_q ? -rem_q : rem_q;
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    bmag_d     = bmag_q;
    result_d   = result_q;
    cnt_d      = cnt_q;
    negq_d     = negq_q;
    negr_d     = negr_q;
    spec_d     = spec_q;
    zero_d     = zero_q;
    div_zero_d = div_zero_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = start ? PREP : IDLE;
        if (start) begin
          a_d        = a;
          b_d        = b;
          op_d       = op;
          div_zero_d = 1'b0;
        end
      end
      PREP: begin
        negq_d  = sgn & (a_q[XLEN-1] ^ b_q[XLEN-1]);
        negr_d  = sgn & a_q[XLEN-1];
        zero_d  = b_q == '0;
        spec_d  = (b_q == '0) | ovf;
        bmag_d  = bm;
        rem_d   = '0;
        cnt_d   = '0;
        quo_d   = amag;
        state_d = ((b_q == '0) | ovf) ? FIX : ITER;
      end
      ITER: begin
        rem_d   = ge ? diff[XLEN-1:0] : rem_w[XLEN-1:0];
        quo_d   = {quo_q[XLEN-2:0], ge};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(XLEN-1)) ? FIX : ITER;
      end
      FIX: begin
        result_d   = zero_q ? (op_q[1] ? a_q : '1) :
                     spec_q ? (op_q[1] ? '0 : MIN_INT) :
                     op_q[1] ? rfin : qfin;
        div_zero_d = zero_q;
        state_d    = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      bmag_q     <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      spec_q     <= 1'b0;
      zero_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      bmag_q     <= bmag_d;
      result_q   <= result_d;
      cnt_q      <= cnt_d;
      negq_q     <= negq_d;
      negr_q     <= negr_d;
      spec_q     <= spec_d;
      zero_q     <= zero_d;
      div_zero_q <= div_zero_d;
    end
  end
  assign ready    = (state_q == IDLE) | (state_q == DONE);
  assign busy     = (state_q == PREP) | (state_q == ITER) | (state_q == FIX);
  assign done     = state_q == DONE;
  assign result   = result_q;
  assign div_zero = div_zero_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider (results, div_zero, latency, handshake)
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [63:0] a = '0, b = '0;
  logic        ready, busy, done, div_zero;
  logic [63:0] result;
  int n_cmp = 0, n_bad = 0, cyc = 0, nid = 0, last_e0 = 0;
  typedef struct {
    logic [63:0] res;
    logic        dz;
    int          e0;
    int          lat;
    int          id;
  } item_t;
  item_t sb[$];
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] M7  = 64'hFFFF_FFFF_FFFF_FFF9;

  seq_divider dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .result(result), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                                output logic [63:0] r, output logic dz, output int lat);
    dz  = 1'b0;
    lat = 66;
    if (y == 0) begin
      r = o[1] ? x : '1; dz = 1'b1; lat = 2;
    end else if (!o[0] && x == MIN && y == '1) begin
      r = o[1] ? '0 : MIN; lat = 2;
    end else
      case (o)
        2'b00:   r = $signed(x) / $signed(y);
        2'b01:   r = x / y;
        2'b10:   r = $signed(x) % $signed(y);
        default: r = x % y;
      endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] er, input logic edz, input int lat);
    item_t it;
    int n = 0;
    while (!ready && n < 300) begin @(negedge clk); n++; end
    if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
    start = 1'b1; op = o; a = x; b = y;
    it.res = er; it.dz = edz; it.e0 = cyc + 1; it.lat = lat; it.id = nid++;
    last_e0 = it.e0;
    sb.push_back(it);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) chk("spurious_done", 64'd1, 64'd0);
      else begin
        item_t it;
        it = sb.pop_front();
        chk($sformatf("res%0d", it.id), result, it.res);
        chk($sformatf("dz%0d", it.id), 64'(div_zero), 64'(it.dz));
        chk($sformatf("lat%0d", it.id), 64'(cyc - it.e0), 64'(it.lat));
      end
    end
  end

  initial begin
    logic [63:0] er, x, y;
    logic        edz;
    logic [1:0]  o;
    int          lat, e1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    issue(2'b00, M7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 66);
    issue(2'b10, M7, 64'd2, '1, 1'b0, 66);
    issue(2'b11, M7, 64'd2, 64'd1, 1'b0, 66);
    e1 = last_e0;
    issue(2'b01, 64'd100, 64'd7, 64'd14, 1'b0, 66);
    chk("b2b_gap", 64'(last_e0 - e1), 64'd67);
    issue(2'b01, '1, 64'd0, '1, 1'b1, 2);
    issue(2'b10, 64'd5, 64'd0, 64'd5, 1'b1, 2);
    issue(2'b00, MIN, '1, MIN, 1'b0, 2);
    issue(2'b10, MIN, '1, 64'd0, 1'b0, 2);
    drain();
    chk("dz_cleared_hold", 64'(div_zero), 64'd0);
    issue(2'b01, 64'd100, 64'd7, 64'd14, 1'b0, 66);
    repeat (10) @(negedge clk);
    start = 1'b1; op = 2'b00; a = 64'd50; b = 64'd5;
    @(negedge clk);
    start = 1'b0;
    drain();
    for (int i = 0; i < 16; i++) begin
      int k;
      o = 2'($urandom_range(0, 3));
      x = {$urandom, $urandom};
      k = int'($urandom_range(0, 2));
      y = (k == 0) ? 64'($urandom_range(1, 20)) : (k == 1) ? {$urandom, $urandom} : -64'($urandom_range(1, 9));
      model(o, x, y, er, edz, lat);
      issue(o, x, y, er, edz, lat);
    end
    drain();
    issue(2'b00, 64'd33, 64'd3, 64'd11, 1'b0, 66);
    while (cyc < last_e0 + 29) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_result", result, 64'd0);
    repeat (80) @(negedge clk);
    issue(2'b00, 64'd33, 64'd3, 64'd11, 1'b0, 66);
    drain();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
